hex_display_scheduler: RTL and testbench

- Drives the board's HEX 7-segment bank from a packed hex value using ONE shared internal hex-to-7-segment decoder (active-low, 7'h7F = all segments off).
- The decoder is time-shared: on each accepted update, a scan FSM feeds one nibble per cycle into the decoder, MSD first, and latches the result into that digit's segment register.
- Adds leading-zero blanking and a global blink function.
- Sits between effect/status logic (level meters, effect-select readouts) and the HEX pins.

---
 rtl/hex_display_scheduler.sv | 73 +++++++
 tb/tb_hex_display_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: scans a packed hex value MSD-first through one shared 7-seg decoder, with leading-zero blanking and blink
module hex_display_scheduler #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] hex_segments
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [111:0] SEG_TAB = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [7*NUM_DIGITS-1:0] digits;
  logic [IW-1:0] idx;
  logic [CW-1:0] blink_cnt;
  logic lz_latched, seen_nz, hidden, accept, blank;
  logic [3:0] nib;
  logic [6:0] seg;
  assign in_ready = state == IDLE;
  assign busy = ~in_ready;
  assign accept = in_valid && in_ready;
  assign nib = shadow[4*idx +: 4];
  assign seg = SEG_TAB[7*nib +: 7];
  assign blank = lz_latched && nib == 4'd0 && !seen_nz && idx != '0;
  assign hex_segments = hidden ? '1 : digits;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = SCAN;
    else if (state == SCAN && idx == '0) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
      digits <= {NUM_DIGITS{7'h7F}};
      idx <= '0;
      lz_latched <= 1'b0;
      seen_nz <= 1'b0;
    end else if (accept) begin
      shadow <= in_value;
      lz_latched <= lz_blank;
      idx <= IW'(NUM_DIGITS - 1);
      seen_nz <= 1'b0;
    end else if (state == SCAN) begin
      digits[7*idx +: 7] <= blank ? 7'h7F : seg;
      seen_nz <= seen_nz | (nib != 4'd0);
      if (idx != '0) idx <= idx - 1'b1;
    end
  end
  // Phase only changes on registered state, so hex_segments has no path from inputs
  always_ff @(posedge clk) begin
    if (!reset_n || !blink_en) begin
      blink_cnt <= '0;
      hidden <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      hidden <= ~hidden;
    end else blink_cnt <= blink_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: directed vectors checked against a digit-level model every cycle
module tb_hex_display_scheduler;
  localparam int N = 6;
  localparam int BD = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4*N-1:0] in_value = '0;
  logic in_valid = 1'b0, lz_blank = 1'b0, blink_en = 1'b0;
  logic in_ready, busy;
  logic [7*N-1:0] hex_segments;
  int vectors = 0, miscompares = 0;

  hex_display_scheduler #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .lz_blank(lz_blank), .blink_en(blink_en), .busy(busy),
    .hex_segments(hex_segments));

  always #5 clk = ~clk;

  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: on accept compute the final picture, then reveal one digit per edge MSD-first
  logic [6:0] m_dig [N];
  logic [6:0] pend [N];
  int step = 0, run = 0;
  bit armed = 0;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_dig[i] = 7'h7F;
      step = 0;
      run = 0;
      armed = 1;
    end else begin
      if (step > 0) begin
        m_dig[N-step] = pend[N-step];
        step = (step == N) ? 0 : step + 1;
      end else if (in_valid) begin
        int msd;
        logic [4*N-1:0] v;
        v = in_value;
        msd = -1;
        for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'd0) msd = i;
        for (int i = 0; i < N; i++)
          pend[i] = (lz_blank && i > msd && i > 0) ? 7'h7F : tab[v[4*i +: 4]];
        step = 1;
      end
      run = blink_en ? run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [7*N-1:0] exp_hex;
      for (int i = 0; i < N; i++) exp_hex[7*i +: 7] = m_dig[i];
      if ((run / BD) % 2 == 1) exp_hex = '1;
      vectors += 3;
      if (hex_segments !== exp_hex) begin
        miscompares++;
        $display("FAIL model_hex t=%0t got %h want %h", $time, hex_segments, exp_hex);
      end
      if (in_ready !== (step == 0)) begin
        miscompares++;
        $display("FAIL model_ready t=%0t got %b want %b", $time, in_ready, step == 0);
      end
      if (busy !== (step != 0)) begin
        miscompares++;
        $display("FAIL model_busy t=%0t got %b want %b", $time, busy, step != 0);
      end
    end
  end

  task automatic chk(input string name, input logic [7*N-1:0] act, input logic [7*N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout waiting for in_ready got 0 want 1");
    end
  endtask

  task automatic send(input logic [4*N-1:0] v, input logic lz);
    int n;
    @(negedge clk);
    wait_ready(n);
    in_value = v;
    lz_blank = lz;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 24'h5A5A5A;
  endtask

  localparam logic [6:0] B = 7'h7F;
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_hex", hex_segments, {N{B}});
    chk("reset_ready", {41'd0, in_ready}, 42'd1);
    chk("reset_busy", {41'd0, busy}, 42'd0);
    reset_n = 1'b1;

    send(24'h0000A5, 1'b1);
    wait_ready(n);
    chk("a5_busy_len", 42'(n), 42'd6);
    chk("a5_digits", hex_segments, {B, B, B, B, 7'b0001000, 7'b0010010});

    send(24'h000000, 1'b1);
    wait_ready(n);
    chk("zero_lz", hex_segments, {B, B, B, B, B, 7'b1000000});
    send(24'h000000, 1'b0);
    wait_ready(n);
    chk("zero_nolz", hex_segments, {N{7'b1000000}});

    send(24'h102030, 1'b1);
    for (int j = 0; j < N; j++) begin
      logic [23:0] v;
      v = 24'h102030;
      @(negedge clk);
      chk("seq_102030", {35'd0, hex_segments[7*(N-1-j) +: 7]}, {35'd0, tab[v[4*(N-1-j) +: 4]]});
    end
    chk("final_102030", hex_segments, {7'b1111001, 7'b1000000, 7'b0100100,
                                        7'b1000000, 7'b0110000, 7'b1000000});

    @(negedge clk);
    wait_ready(n);
    in_value = 24'h123456;
    lz_blank = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_value = 24'hABCDEF;
    n = 1;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_gap", 42'(n), 42'd7);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 24'h777777;
    wait_ready(n);
    chk("final_abcdef", hex_segments, {7'b0001000, 7'b0000011, 7'b1000110,
                                        7'b0100001, 7'b0000110, 7'b0001110});

    send(24'h000001, 1'b1);
    wait_ready(n);
    blink_en = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("blink_phase", hex_segments,
          ((j / 4) % 2 == 1) ? {N{B}} : {B, B, B, B, B, 7'b1111001});
    end
    blink_en = 1'b0;
    @(negedge clk);
    chk("blink_drop", hex_segments, {B, B, B, B, B, 7'b1111001});
    blink_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("blink_restart_vis", hex_segments, {B, B, B, B, B, 7'b1111001});
    @(negedge clk);
    chk("blink_restart_hid", hex_segments, {N{B}});
    blink_en = 1'b0;
    @(negedge clk);

    send(24'hFFFFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("partial_ff", hex_segments, {7'b0001110, 7'b0001110, B, B, B, 7'b1111001});
    reset_n = 1'b0;
    @(negedge clk);
    chk("midscan_reset_hex", hex_segments, {N{B}});
    chk("midscan_reset_ready", {41'd0, in_ready}, 42'd1);
    chk("midscan_reset_busy", {41'd0, busy}, 42'd0);
    reset_n = 1'b1;
    send(24'h123456, 1'b0);
    wait_ready(n);
    chk("after_reset", hex_segments, {7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010});
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
